// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory block responder.
// Holds the block FSM state encoding, block geometry and access-size helpers.
package dmem_resp_pkg;

  localparam int BLK_WORDS = 8;
  localparam int BLK_BITS  = 256;

  typedef enum logic [2:0] {
    IDLE,
    RBUSY,
    WBUSY,
    RDONE,
    WDONE
  } blkStateT;

  typedef enum logic [1:0] {
    SIZE_4B = 2'd0,
    SIZE_1B = 2'd1,
    SIZE_2B = 2'd2,
    SIZE_3B = 2'd3
  } sizeT;

  // A size code of zero encodes a full 4-byte word.
  function automatic logic [2:0] sizeBytes(logic [1:0] size);
    return (size == SIZE_4B) ? 3'd4 : {1'b0, size};
  endfunction

endpackage

// File: rtl/dmem_block_responder_if.sv
// CPU-side data-memory bus: word read/write plus four-phase block read/write.
// The CPU drives the master modport; the responder implements the slave modport.
interface dmem_block_responder_if;
  import dmem_resp_pkg::*;

  logic [31:0]         data_address_fCPU;
  logic                MemRead_fCPU;
  logic                MemWrite_fCPU;
  logic [31:0]         data_write_fCPU;
  logic [1:0]          data_write_size_fCPU;
  logic [31:0]         data_read_2CPU;
  logic                dBlkRead_fCPU;
  logic                dBlkWrite_fCPU;
  logic [BLK_BITS-1:0] block_write_fCPU;
  logic [BLK_BITS-1:0] block_read_2CPU;
  logic                block_read_valid_2CPU;
  logic                block_write_valid_2CPU;
  logic                addr_err_2CPU;

  modport master (
    output data_address_fCPU, MemRead_fCPU, MemWrite_fCPU, data_write_fCPU,
           data_write_size_fCPU, dBlkRead_fCPU, dBlkWrite_fCPU, block_write_fCPU,
    input  data_read_2CPU, block_read_2CPU, block_read_valid_2CPU,
           block_write_valid_2CPU, addr_err_2CPU
  );

  modport slave (
    input  data_address_fCPU, MemRead_fCPU, MemWrite_fCPU, data_write_fCPU,
           data_write_size_fCPU, dBlkRead_fCPU, dBlkWrite_fCPU, block_write_fCPU,
    output data_read_2CPU, block_read_2CPU, block_read_valid_2CPU,
           block_write_valid_2CPU, addr_err_2CPU
  );

endinterface

// File: rtl/dmem_resp_array.sv
// Word storage: combinational word and 8-word block read ports,
// byte-enabled word write and full-block write on the rising clock edge.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic [AW-1:0]       wordIdx,
  output logic [31:0]         wordRdData,
  input  logic                wordWe,
  input  logic [3:0]          byteEn,
  input  logic [31:0]         wordWrData,
  input  logic [AW-1:0]       blkIdx,
  output logic [BLK_BITS-1:0] blkRdData,
  input  logic                blkWe,
  input  logic [BLK_BITS-1:0] blkWrData
);

  logic [31:0] mem [DEPTH_WORDS];

  assign wordRdData = mem[wordIdx];

  always_comb begin
    blkRdData = '0;
    for (int k = 0; k < BLK_WORDS; k++) begin
      blkRdData[32*k +: 32] = mem[blkIdx | AW'(k)];
    end
  end

  // NOTE: storage has no reset; its contents survive RESET and only control state is cleared.
  always_ff @(posedge clk) begin
    if (wordWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wordWrData[8*b +: 8];
      end
    end
    // Issued last so a same-edge block commit overrides a word write to the same block.
    if (blkWe) begin
      for (int k = 0; k < BLK_WORDS; k++) begin
        mem[blkIdx | AW'(k)] <= blkWrData[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/dmem_block_responder.sv
// Data-memory responder: combinational word reads, byte-lane word writes and a
// latency-modelled four-phase block FSM. Define DMEM_RESP_BOUNDS_EN for range checking.
module dmem_block_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int BLK_LATENCY = 8
) (
  input logic                   CLK,
  input logic                   RESET,
  dmem_block_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0] LAT_LOAD = 8'(BLK_LATENCY - 1);

  blkStateT            state, stateNext;
  logic [7:0]          cnt, cntNext;
  logic [26:0]         blkBase, blkBaseNext;
  logic [BLK_BITS-1:0] blkRead;
  logic                captureEn, blkWe;
  logic                curOob, blkOob;
  logic [29:0]         blkWordAddr;
  logic [AW-1:0]       wordIdx, blkIdx;
  logic [31:0]         wordRdData, wordWrData;
  logic [BLK_BITS-1:0] blkRdData;
  logic [3:0]          byteEn;
  logic [2:0]          nBytes;
  logic [1:0]          off, srcByte;

  assign wordIdx     = bus.data_address_fCPU[AW+1:2];
  assign blkWordAddr = {blkBase, 3'b000};
  assign blkIdx      = blkWordAddr[AW-1:0];

`ifdef DMEM_RESP_BOUNDS_EN
  assign curOob = bus.data_address_fCPU[31:2] >= 30'(DEPTH_WORDS);
  assign blkOob = blkWordAddr >= 30'(DEPTH_WORDS);
  assign bus.addr_err_2CPU = curOob && (bus.MemRead_fCPU || bus.MemWrite_fCPU ||
                                        bus.dBlkRead_fCPU || bus.dBlkWrite_fCPU);
`else
  logic unusedAddrBits;
  assign unusedAddrBits    = ^{bus.data_address_fCPU[31:AW+2], blkWordAddr[29:AW]};
  assign curOob            = 1'b0;
  assign blkOob            = 1'b0;
  assign bus.addr_err_2CPU = 1'b0;
`endif

  // Big-endian lanes: offset p lives in lane 3-p; the N low-order data bytes fill
  // offsets off..off+N-1 most-significant first, and anything past offset 3 is dropped.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    byteEn     = '0;
    wordWrData = '0;
    srcByte    = '0;
    nBytes     = sizeBytes(bus.data_write_size_fCPU);
    off        = bus.data_address_fCPU[1:0];
    for (int p = 0; p < 4; p++) begin
      if (p >= int'(off) && (p - int'(off)) < int'(nBytes)) begin
        srcByte                  = 2'(int'(nBytes) - 1 - (p - int'(off)));
        byteEn[3-p]              = 1'b1;
        wordWrData[8*(3-p) +: 8] = bus.data_write_fCPU[{srcByte, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    blkBaseNext = blkBase;
    captureEn   = 1'b0;
    blkWe       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dBlkWrite_fCPU) begin
          stateNext   = WBUSY;
          cntNext     = LAT_LOAD;
          blkBaseNext = bus.data_address_fCPU[31:5];
        end else if (bus.dBlkRead_fCPU) begin
          stateNext   = RBUSY;
          cntNext     = LAT_LOAD;
          blkBaseNext = bus.data_address_fCPU[31:5];
        end
      end
      RBUSY: begin
        if (!bus.dBlkRead_fCPU) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = RDONE;
          captureEn = 1'b1;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end
      WBUSY: begin
        if (!bus.dBlkWrite_fCPU) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = WDONE;
          blkWe     = !blkOob;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end
      RDONE:   if (!bus.dBlkRead_fCPU)  stateNext = IDLE;
      WDONE:   if (!bus.dBlkWrite_fCPU) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      blkBase <= '0;
      blkRead <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      blkBase <= blkBaseNext;
      if (captureEn) blkRead <= blkOob ? '0 : blkRdData;
    end
  end

  assign bus.block_read_2CPU        = blkRead;
  assign bus.block_read_valid_2CPU  = (state == RDONE);
  assign bus.block_write_valid_2CPU = (state == WDONE);
  assign bus.data_read_2CPU         = (bus.MemRead_fCPU && !curOob) ? wordRdData : '0;

  dmem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk       (CLK),
    .wordIdx   (wordIdx),
    .wordRdData(wordRdData),
    .wordWe    (bus.MemWrite_fCPU && !curOob),
    .byteEn    (byteEn),
    .wordWrData(wordWrData),
    .blkIdx    (blkIdx),
    .blkRdData (blkRdData),
    .blkWe     (blkWe),
    .blkWrData (bus.block_write_fCPU)
  );

endmodule

// File: tb/tb_dmem_block_responder.sv
// Scoreboard bench for dmem_block_responder: stimulus pushes expected responses
// computed from a byte-addressed reference memory; a negedge monitor pops and compares.
module tb_dmem_block_responder;
  import dmem_resp_pkg::*;

  localparam int DEPTH = 4096;
  localparam int LAT   = 8;
  localparam int MEMB  = DEPTH * 4;

  logic CLK = 1'b0;
  logic RESET;

  dmem_block_responder_if bus ();

  dmem_block_responder #(
    .DEPTH_WORDS(DEPTH),
    .BLK_LATENCY(LAT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_WORD = 0, K_BLKRD = 1, K_BLKWR = 2} kindT;
  typedef struct {
    kindT                kind;
    logic [BLK_BITS-1:0] data;
  } expT;

  expT         expQ[$];
  byte unsigned refMem [MEMB];
  int          checks = 0;
  int          errors = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte addressed, big-endian words) ----------------
  function automatic bit inRange(logic [31:0] a);
`ifdef DMEM_RESP_BOUNDS_EN
    return {2'b00, a[31:2]} < 32'(DEPTH);
`else
    return (a === a);
`endif
  endfunction

  function automatic int byteIdx(logic [31:0] a);
    return int'(a & 32'(MEMB - 1));
  endfunction

  function automatic logic [31:0] refWord(logic [31:0] a);
    int b;
    if (!inRange(a)) return '0;
    b = byteIdx(a) & ~3;
    return {refMem[b], refMem[b+1], refMem[b+2], refMem[b+3]};
  endfunction

  function automatic void refWrite(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    int n, o, b;
    if (!inRange(a)) return;
    n = (sz == 2'd0) ? 4 : int'(sz);
    o = int'(a[1:0]);
    b = byteIdx(a) & ~3;
    for (int i = 0; i < n; i++) begin
      if (o + i < 4) refMem[b + o + i] = 8'(d >> (8 * (n - 1 - i)));
    end
  endfunction

  function automatic logic [255:0] refBlock(logic [31:0] a);
    logic [255:0] r;
    logic [31:0]  base;
    base = a & ~32'd31;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = refWord(base + 32'(4 * k));
    return r;
  endfunction

  function automatic void refBlkWrite(logic [31:0] a, logic [255:0] d);
    logic [31:0] base;
    base = a & ~32'd31;
    for (int k = 0; k < 8; k++) refWrite(base + 32'(4 * k), d[32*k +: 32], 2'd0);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- monitor ----------------
  task automatic popCheck(kindT k, logic [255:0] act);
    expT e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output actual=kind%0d required=none", int'(k));
      return;
    end
    checks--;
    e = expQ.pop_front();
    check("output_kind", 256'(int'(k)), 256'(int'(e.kind)));
    if (k == K_WORD)  check("word_read_data", act, e.data);
    if (k == K_BLKRD) check("block_read_data", act, e.data);
  endtask

  logic prevRv = 1'b0;
  logic prevWv = 1'b0;
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      if (bus.MemRead_fCPU === 1'b1) popCheck(K_WORD, {224'b0, bus.data_read_2CPU});
      if (bus.block_read_valid_2CPU === 1'b1 && !prevRv) popCheck(K_BLKRD, bus.block_read_2CPU);
      if (bus.block_write_valid_2CPU === 1'b1 && !prevWv) popCheck(K_BLKWR, '0);
    end
    prevRv = (bus.block_read_valid_2CPU === 1'b1);
    prevWv = (bus.block_write_valid_2CPU === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wordWrite(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    bus.data_address_fCPU    = a;
    bus.data_write_fCPU      = d;
    bus.data_write_size_fCPU = sz;
    bus.MemWrite_fCPU        = 1'b1;
    step();
    refWrite(a, d, sz);
    bus.MemWrite_fCPU = 1'b0;
  endtask

  task automatic wordReadExp(logic [31:0] a, logic [31:0] exp);
    bus.data_address_fCPU = a;
    bus.MemRead_fCPU      = 1'b1;
    expQ.push_back('{K_WORD, 256'(exp)});
    step();
    bus.MemRead_fCPU = 1'b0;
  endtask

  task automatic wordRead(logic [31:0] a);
    wordReadExp(a, refWord(a));
  endtask

  task automatic waitFor(bit wr, output int lat);
    lat = 0;
    while ((wr ? bus.block_write_valid_2CPU : bus.block_read_valid_2CPU) !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    if (lat >= 400)
      check("valid_timeout", 256'(wr ? bus.block_write_valid_2CPU : bus.block_read_valid_2CPU), 256'(1));
  endtask

  task automatic blockOp(bit wr, logic [31:0] a, logic [255:0] d, int hold);
    int lat;
    bus.data_address_fCPU = a;
    bus.block_write_fCPU  = d;
    if (wr) begin
      expQ.push_back('{K_BLKWR, '0});
      bus.dBlkWrite_fCPU = 1'b1;
    end else begin
      expQ.push_back('{K_BLKRD, refBlock(a)});
      bus.dBlkRead_fCPU = 1'b1;
    end
    step();
    bus.data_address_fCPU = $urandom;  // base must already be latched
    waitFor(wr, lat);
    check("blk_latency", 256'(lat), 256'(LAT));
    if (wr) refBlkWrite(a, d);
    repeat (hold) begin
      step();
      check("valid_hold", 256'(wr ? bus.block_write_valid_2CPU : bus.block_read_valid_2CPU), 256'(1));
    end
    bus.dBlkWrite_fCPU = 1'b0;
    bus.dBlkRead_fCPU  = 1'b0;
    step();
    check("valid_drop", 256'(wr ? bus.block_write_valid_2CPU : bus.block_read_valid_2CPU), 256'(0));
  endtask

  task automatic abortOp(bit wr, logic [31:0] a, logic [255:0] d, int dropAt);
    bus.data_address_fCPU = a;
    bus.block_write_fCPU  = d;
    if (wr) bus.dBlkWrite_fCPU = 1'b1;
    else    bus.dBlkRead_fCPU  = 1'b1;
    step();
    repeat (dropAt - 1) step();
    bus.dBlkWrite_fCPU = 1'b0;
    bus.dBlkRead_fCPU  = 1'b0;
    repeat (2) begin
      step();
      check("abort_no_valid", 256'({bus.block_write_valid_2CPU, bus.block_read_valid_2CPU}), 256'(0));
    end
  endtask

  task automatic coincide(logic [31:0] blkA, logic [31:0] wordA);
    logic [255:0] d;
    logic [31:0]  w;
    d = rand256();
    w = $urandom;
    bus.data_address_fCPU = blkA;
    bus.block_write_fCPU  = d;
    bus.dBlkWrite_fCPU    = 1'b1;
    expQ.push_back('{K_BLKWR, '0});
    step();
    repeat (LAT - 1) step();
    bus.data_address_fCPU    = wordA;
    bus.data_write_fCPU      = w;
    bus.data_write_size_fCPU = 2'd0;
    bus.MemWrite_fCPU        = 1'b1;
    step();
    check("coincide_commit_edge", 256'(bus.block_write_valid_2CPU), 256'(1));
    bus.MemWrite_fCPU = 1'b0;
    refWrite(wordA, w, 2'd0);
    refBlkWrite(blkA, d);
    bus.dBlkWrite_fCPU = 1'b0;
    step();
  endtask

  // ---------------- main sequence ----------------
  logic [31:0]  blocks [4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_3FE0};
  logic [255:0] pat;
  int           lat;

  initial begin
    RESET                    = 1'b0;
    bus.data_address_fCPU    = '0;
    bus.MemRead_fCPU         = 1'b0;
    bus.MemWrite_fCPU        = 1'b0;
    bus.data_write_fCPU      = '0;
    bus.data_write_size_fCPU = '0;
    bus.dBlkRead_fCPU        = 1'b0;
    bus.dBlkWrite_fCPU       = 1'b0;
    bus.block_write_fCPU     = '0;
    #2;
    check("reset_rd_valid", 256'(bus.block_read_valid_2CPU), 256'(0));
    check("reset_wr_valid", 256'(bus.block_write_valid_2CPU), 256'(0));
    check("reset_blk_data", bus.block_read_2CPU, 256'(0));
    check("reset_addr_err", 256'(bus.addr_err_2CPU), 256'(0));
    step();
    RESET = 1'b1;
    step();

    foreach (blocks[i]) blockOp(1'b1, blocks[i], rand256(), 0);

    // word write then read back
    wordWrite(32'h100, 32'hDEAD_BEEF, 2'd0);
    wordReadExp(32'h100, 32'hDEAD_BEEF);

    // block read latency and hold
    blockOp(1'b0, 32'h100, '0, 3);
    check("blk_word0", 256'(bus.block_read_2CPU[31:0]), 256'(32'hDEAD_BEEF));

    // partial writes, including dropped lanes past offset 3
    wordWrite(32'h101, 32'h0000_00AB, 2'd1);
    wordReadExp(32'h100, 32'hDEAB_BEEF);
    wordWrite(32'h102, 32'h0012_3456, 2'd3);
    wordReadExp(32'h100, 32'hDEAB_1234);
    wordReadExp(32'h104, refWord(32'h104));

    // simultaneous block read and write: write first, then the read
    pat = rand256();
    bus.data_address_fCPU = 32'h200;
    bus.block_write_fCPU  = pat;
    bus.dBlkWrite_fCPU    = 1'b1;
    bus.dBlkRead_fCPU     = 1'b1;
    expQ.push_back('{K_BLKWR, '0});
    step();
    waitFor(1'b1, lat);
    check("wr_wins_latency", 256'(lat), 256'(LAT));
    refBlkWrite(32'h200, pat);
    expQ.push_back('{K_BLKRD, refBlock(32'h200)});
    bus.dBlkWrite_fCPU   = 1'b0;
    bus.block_write_fCPU = ~pat;
    waitFor(1'b0, lat);
    check("wr_then_rd_pattern", bus.block_read_2CPU, pat);
    bus.dBlkRead_fCPU = 1'b0;
    step();

    // aborted block write leaves memory unchanged
    abortOp(1'b1, 32'h200, ~pat, 3);
    abortOp(1'b1, 32'h200, ~pat, LAT);
    blockOp(1'b0, 32'h200, '0, 0);
    check("abort_kept_pattern", bus.block_read_2CPU, pat);

    // word and block commits on the same edge
    coincide(32'h200, 32'h204);
    coincide(32'h200, 32'h104);
    wordRead(32'h204);
    wordRead(32'h104);

    // reset while busy and while done
    bus.data_address_fCPU = 32'h200;
    bus.dBlkRead_fCPU     = 1'b1;
    repeat (3) step();
    RESET = 1'b0;
    #1;
    check("rst_rbusy_valid", 256'(bus.block_read_valid_2CPU), 256'(0));
    check("rst_rbusy_blkdata", bus.block_read_2CPU, 256'(0));
    bus.dBlkRead_fCPU = 1'b0;
    step();
    RESET = 1'b1;
    repeat (2) step();
    check("rst_rbusy_idle", 256'(bus.block_read_valid_2CPU), 256'(0));

    expQ.push_back('{K_BLKRD, refBlock(32'h100)});
    bus.data_address_fCPU = 32'h100;
    bus.dBlkRead_fCPU     = 1'b1;
    step();
    waitFor(1'b0, lat);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("rst_rdone_valid", 256'(bus.block_read_valid_2CPU), 256'(0));
    check("rst_rdone_blkdata", bus.block_read_2CPU, 256'(0));
    bus.dBlkRead_fCPU = 1'b0;
    step();
    RESET = 1'b1;
    step();
    blockOp(1'b0, 32'h200, '0, 1);

    // out-of-range word write
    bus.data_address_fCPU    = 32'h4000;
    bus.data_write_fCPU      = 32'hCAFE_F00D;
    bus.data_write_size_fCPU = 2'd0;
    bus.MemWrite_fCPU        = 1'b1;
    #1;
`ifdef DMEM_RESP_BOUNDS_EN
    check("oob_addr_err", 256'(bus.addr_err_2CPU), 256'(1));
`else
    check("oob_addr_err", 256'(bus.addr_err_2CPU), 256'(0));
`endif
    step();
    refWrite(32'h4000, 32'hCAFE_F00D, 2'd0);
    bus.MemWrite_fCPU = 1'b0;
    #1;
    check("oob_err_idle", 256'(bus.addr_err_2CPU), 256'(0));
    wordRead(32'h0);
    wordRead(32'h4000);
`ifndef DMEM_RESP_BOUNDS_EN
    wordReadExp(32'h0, 32'hCAFE_F00D);
`endif

    // randomized mix over initialised blocks
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = blocks[$urandom_range(0, 3)] + 32'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0:       wordWrite(a, $urandom, 2'($urandom_range(0, 3)));
        1:       wordRead(a);
        2:       blockOp(1'b0, a, '0, $urandom_range(0, 2));
        3:       blockOp(1'b1, a, rand256(), $urandom_range(0, 2));
        default: abortOp(1'($urandom_range(0, 1)), a, rand256(), $urandom_range(1, LAT));
      endcase
    end
    foreach (blocks[i]) blockOp(1'b0, blocks[i], '0, 0);

    repeat (2) step();
    check("scoreboard_drained", 256'(expQ.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
